// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the scoreboarded register file
//
// Purpose: the scrub/run FSM state encoding, default geometry and the
// zero-register index, shared by regfile_mp_sb and regfile_sb_scoreboard.
// Ports: none (package).
package regfile_pkg;

  typedef enum logic {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int ZERO_IDX     = 0;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// rtl/regfile_sb_scoreboard.sv - per-register pending bits with two lookup ports
//
// Purpose: one pending bit per architectural register. A reservation sets the
// bit, a writeback clears it; a same-cycle set and clear on one register
// leaves it set, because the reservation belongs to a younger instruction.
// With ZERO_REG the zero register is never pending.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset (clears all bits)
//   set_en, set_addr         reserve a register (already gated by the caller)
//   clr_en, clr_addr         writeback clear (already gated by the caller)
//   look_addr_a/b, pend_a/b  combinational lookups of the current pending state
module regfile_sb_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] look_addr_a,
  input  logic [ADDR_W-1:0] look_addr_b,
  output logic              pend_a,
  output logic              pend_b
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;

  // Clear first, then set, so the reservation wins on an address collision.
  always_comb begin
    pending_next = pending;
    if (clr_en) pending_next[clr_addr] = 1'b0;
    if (set_en) pending_next[set_addr] = 1'b1;
    if (ZERO_REG != 0) pending_next[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

  assign pend_a = pending[look_addr_a];
  assign pend_b = pending[look_addr_b];

endmodule

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - 2R/1W register file with pending scoreboard and post-reset scrub
//
// Purpose: architectural register file between decode (reads, reservations)
// and writeback (writes). Reads are registered (1-cycle latency). After reset
// a scrub FSM writes zero to one entry per cycle, so the array itself carries
// no reset; busy is high for NUM_REGS cycles and all requests are ignored.
// Optional build macro REGFILE_BYPASS_EN: a same-cycle write to the address
// being read is forwarded to the read port (data and ready). Without it the
// read sees the pre-write value and pending state.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rd_en_a/b, rd_addr_a/b        read requests
//   rd_data_a/b, rd_ready_a/b     registered read data; ready = not pending
//   rsv_en, rsv_addr              mark a register pending
//   wr_en, wr_addr, wr_data       writeback (clears pending)
//   busy                          high while scrubbing
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_ready_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_ready_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cnt;
  logic              scrub_we;
  logic              scrub_last;

  logic [DATA_W-1:0] mem [NUM_REGS];

  logic              rd_fire_a;
  logic              rd_fire_b;
  logic              rsv_fire;
  logic              wr_fire;
  logic              pend_a;
  logic              pend_b;
  logic [DATA_W:0]   look_a;
  logic [DATA_W:0]   look_b;

  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_IDX));
  endfunction

  assign scrub_last = (cnt == ADDR_W'(NUM_REGS - 1));

  // FSM: state register and scrub counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SCRUB;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (scrub_we) cnt <= cnt + 1'b1;
    end
  end

  // FSM: next state. RUN is terminal; only reset returns to SCRUB.
  always_comb begin
    state_next = state;
    if (state == SCRUB && scrub_last) state_next = RUN;
  end

  // FSM: outputs
  always_comb begin
    busy     = 1'b0;
    scrub_we = 1'b0;
    if (state == SCRUB) begin
      busy     = 1'b1;
      scrub_we = 1'b1;
    end
  end

  assign rd_fire_a = rd_en_a && !busy;
  assign rd_fire_b = rd_en_b && !busy;
  assign rsv_fire  = rsv_en && !busy && !is_zero(rsv_addr);
  assign wr_fire   = wr_en && !busy && !is_zero(wr_addr);

  // Storage has no reset; the scrub pass is what zeroes it.
  always_ff @(posedge clk) begin
    if (scrub_we)     mem[cnt]     <= '0;
    else if (wr_fire) mem[wr_addr] <= wr_data;
  end

  regfile_sb_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en      (rsv_fire),
    .set_addr    (rsv_addr),
    .clr_en      (wr_fire),
    .clr_addr    (wr_addr),
    .look_addr_a (rd_addr_a),
    .look_addr_b (rd_addr_b),
    .pend_a      (pend_a),
    .pend_b      (pend_b)
  );

  // Returns {data, ready} for one read port.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] addr,
                                             input logic              pend);
    logic [DATA_W:0] r;
    if (is_zero(addr)) begin
      r = {{DATA_W{1'b0}}, 1'b1};
    end else begin
      r = {mem[addr], !pend};
`ifdef REGFILE_BYPASS_EN
      // Forward the in-flight writeback; a same-cycle reservation of this
      // register belongs to a younger producer, so it is still not ready.
      if (wr_fire && wr_addr == addr)
        r = {wr_data, !(rsv_fire && rsv_addr == addr)};
`endif
    end
    return r;
  endfunction

  assign look_a = lookup(rd_addr_a, pend_a);
  assign look_b = lookup(rd_addr_b, pend_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_a  <= '0;
      rd_ready_a <= 1'b1;
      rd_data_b  <= '0;
      rd_ready_b <= 1'b1;
    end else begin
      if (rd_fire_a) {rd_data_a, rd_ready_a} <= look_a;
      if (rd_fire_b) {rd_data_b, rd_ready_b} <= look_b;
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - scoreboard-checked bench for regfile_mp_sb
module tb_regfile_mp_sb;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_en_a = 1'b0, rd_en_b = 1'b0;
  logic [ADDR_W-1:0] rd_addr_a = '0, rd_addr_b = '0;
  logic [DATA_W-1:0] rd_data_a, rd_data_b;
  logic              rd_ready_a, rd_ready_b;
  logic              rsv_en = 1'b0;
  logic [ADDR_W-1:0] rsv_addr = '0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              busy;

  always #5 clk = ~clk;

  regfile_mp_sb dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en_a    (rd_en_a),
    .rd_addr_a  (rd_addr_a),
    .rd_data_a  (rd_data_a),
    .rd_ready_a (rd_ready_a),
    .rd_en_b    (rd_en_b),
    .rd_addr_b  (rd_addr_b),
    .rd_data_b  (rd_data_b),
    .rd_ready_b (rd_ready_b),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              ready;
    string             name;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  logic issued_a = 1'b0, issued_b = 1'b0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [DATA_W-1:0] d, input logic r, input string n);
    exp_t e;
    e.data = d; e.ready = r; e.name = n;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [DATA_W-1:0] d, input logic r, input string n);
    exp_t e;
    e.data = d; e.ready = r; e.name = n;
    qb.push_back(e);
  endtask

  // Monitor: a read accepted at a posedge is compared at the following negedge.
  always @(posedge clk) begin
    issued_a <= rd_en_a && !rst;
    issued_b <= rd_en_b && !rst;
  end

  always @(negedge clk) begin
    exp_t e;
    if (issued_a) begin
      if (qa.size() == 0) chk("a_unexpected_read", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        chk({e.name, "_a_data"}, rd_data_a, e.data);
        chk({e.name, "_a_ready"}, {31'd0, rd_ready_a}, {31'd0, e.ready});
      end
    end
    if (issued_b) begin
      if (qb.size() == 0) chk("b_unexpected_read", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        chk({e.name, "_b_data"}, rd_data_b, e.data);
        chk({e.name, "_b_ready"}, {31'd0, rd_ready_b}, {31'd0, e.ready});
      end
    end
  end

  // Apply the currently driven request for one posedge, then drop enables.
  task automatic step();
    @(negedge clk);
    rd_en_a = 1'b0; rd_en_b = 1'b0; rsv_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic rd_a(input int a);
    rd_en_a = 1'b1; rd_addr_a = ADDR_W'(a);
  endtask
  task automatic rd_b(input int a);
    rd_en_b = 1'b1; rd_addr_b = ADDR_W'(a);
  endtask
  task automatic wr(input int a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
  endtask
  task automatic rsv(input int a);
    rsv_en = 1'b1; rsv_addr = ADDR_W'(a);
  endtask

  // Counts busy cycles after reset release, firing requests that must be ignored.
  task automatic scrub_count(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      wr(4, 32'h99); rsv(6); rd_a(4); rd_b(6);
      push_a(32'h0, 1'b1, "busy_ign");
      push_b(32'h0, 1'b1, "busy_ign");
      step();
    end
  endtask

  int n;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_data_a", rd_data_a, 32'h0);
    chk("rst_ready_a", {31'd0, rd_ready_a}, 32'd1);
    chk("rst_data_b", rd_data_b, 32'h0);
    chk("rst_ready_b", {31'd0, rd_ready_b}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd1);

    rst = 1'b0;
    scrub_count(n);
    chk("busy_cycles", n, NUM_REGS);

    rd_a(5); push_a(32'h0, 1'b1, "scrub_x5"); step();

    wr(7, 32'hDEADBEEF); step();
    rd_a(7); rd_b(7);
    push_a(32'hDEADBEEF, 1'b1, "x7"); push_b(32'hDEADBEEF, 1'b1, "x7"); step();

    wr(0, 32'h1234); step();
    rd_a(0); push_a(32'h0, 1'b1, "x0_wr"); step();
    rsv(0); step();
    rd_b(0); push_b(32'h0, 1'b1, "x0_rsv"); step();

    rsv(3); step();
    rd_a(3); push_a(32'h0, 1'b0, "x3_rsv"); step();
    wr(3, 32'h55); step();
    rd_a(3); push_a(32'h55, 1'b1, "x3_wr"); step();
    rsv(3); wr(3, 32'h66); step();
    rd_a(3); push_a(32'h66, 1'b0, "x3_both"); step();
    rsv(3); step();
    wr(3, 32'h77); step();
    rd_b(3); push_b(32'h77, 1'b1, "x3_nocount"); step();

    wr(9, 32'h1111); step();
    wr(9, 32'hAAAA); rd_a(9);
    push_a(BYP ? 32'hAAAA : 32'h1111, 1'b1, "coll_x9"); step();
    rd_b(9); push_b(32'hAAAA, 1'b1, "after_x9"); step();
    rsv(9); wr(9, 32'hBBBB); rd_a(9);
    push_a(BYP ? 32'hBBBB : 32'hAAAA, BYP ? 1'b0 : 1'b1, "coll_rsv_x9"); step();
    rd_b(9); push_b(32'hBBBB, 1'b0, "x9_pend"); step();
    rsv(10); step();
    wr(10, 32'hCC); rd_a(10);
    push_a(BYP ? 32'hCC : 32'h0, BYP ? 1'b1 : 1'b0, "coll_x10"); step();

    rd_a(7); push_a(32'hDEADBEEF, 1'b1, "hold_pre"); step();
    for (int i = 0; i < 3; i++) begin
      wr(2, 32'h200 + i); step();
      chk("hold_a", rd_data_a, 32'hDEADBEEF);
    end
    rd_b(2); push_b(32'h202, 1'b1, "x2"); step();

    wr(4, 32'h77); step();
    rsv(6); step();
    rd_a(4); rd_b(6);
    push_a(32'h77, 1'b1, "x4_pre"); push_b(32'h0, 1'b0, "x6_pre"); step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_data_a", rd_data_a, 32'h0);
    chk("mid_rst_ready_b", {31'd0, rd_ready_b}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    scrub_count(n);
    chk("busy_cycles_2", n, NUM_REGS);
    rd_a(4); rd_b(6);
    push_a(32'h0, 1'b1, "x4_post"); push_b(32'h0, 1'b1, "x6_post"); step();

    repeat (3) step();
    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the core's 32x32 integer register file.
- Two read ports are registered (1-cycle latency) and there is one write port.
- A per-register pending scoreboard supports in-flight writebacks.
- After reset, a scrub FSM clears the array one entry per cycle, so no large flop-reset fan-out is needed.
- Sits between the decode stage (reads and reservations) and the writeback stage (writes).

Parameters:
- DATA_W, 32: register width in bits.
- NUM_REGS, 32: number of architectural registers; power of two, at least 2.
- ADDR_W, $clog2(NUM_REGS): address width (derived; do not override).
- ZERO_REG, 1: when 1, register 0 reads as 0, ignores writes and is never pending.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_en_a  in  1  read port A enable.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_data_a  out  DATA_W  registered read data, port A.
- rd_ready_a  out  1  registered; 1 = the addressed register had no pending write.
- rd_en_b, rd_addr_b, rd_data_b, rd_ready_b: identical to port A, for port B.
- rsv_en  in  1  mark register rsv_addr as pending (issued instruction will write it).
- rsv_addr  in  ADDR_W  register to reserve.
- wr_en  in  1  writeback enable.
- wr_addr  in  ADDR_W  writeback address.
- wr_data  in  DATA_W  writeback data.
- busy  out  1  1 while scrubbing; all requests are ignored while busy.

Behaviour:
- Reset: one clock and reset only; rst is asynchronous and active-high. Asserting rst immediately forces:
  - rd_data_a/b = 0, rd_ready_a/b = 1, busy = 1;
  - all pending bits = 0;
  - FSM = SCRUB, scrub counter = 0.
  - The storage array is not reset directly.
- SCRUB state:
  - Each cycle writes 0 to mem[cnt] and increments cnt.
  - When cnt == NUM_REGS-1 that write completes and the FSM goes to RUN, so busy is high for exactly NUM_REGS cycles after rst deasserts.
  - rd_en, rsv_en and wr_en are ignored; rd_data holds 0 and rd_ready holds 1.
- RUN state:
  - Terminal; only rst leaves it, by returning to SCRUB.
  - Reasserting rst mid-scrub or mid-operation restarts the scrub from 0.
- Write:
  - When wr_en, mem[wr_addr] <= wr_data at posedge.
  - Suppressed when ZERO_REG && wr_addr == 0.
- Read:
  - When rd_en_x, at posedge rd_data_x <= mem[rd_addr_x] and rd_ready_x <= !pending[rd_addr_x].
  - When !rd_en_x, both outputs hold their previous values.
  - ZERO_REG && addr == 0 gives data 0 and ready 1.
- Scoreboard:
  - wr_en clears pending[wr_addr]; rsv_en sets pending[rsv_addr].
  - If both target the same address in the same cycle, the set wins (a newer reservation overrides the old writeback).
  - rsv_en on a register that is already pending leaves it pending (no counting).
  - With ZERO_REG, address 0 never becomes pending.
- Same-cycle read and write of the same address: the read returns the OLD value and the OLD pending state, unless the optional feature is enabled.
- Ports A and B are fully independent and may read the same address.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: when wr_en && rd_en_x && wr_addr == rd_addr_x (and the address is not the zero register), rd_data_x takes wr_data and rd_ready_x = 1, unless rsv_en to that same address in the same cycle, in which case rd_ready_x = 0. Adds a comparator and mux per read port.
- Undefined: reads return the pre-write value and pending state, as in Behaviour.

Decomposition:
- Shared package regfile_pkg holds:
  - FSM state encoding (SCRUB = 1'b0, RUN = 1'b1);
  - default DATA_W/NUM_REGS constants;
  - the zero-register index constant.
- One sub-module, regfile_sb_scoreboard: the NUM_REGS-bit pending vector with set/clear priority and two combinational lookup ports.
- Storage, scrub FSM and read registers stay in the top level.

Test Plan:
- Scrub and zero: release rst, count busy cycles (expect 32), then read x5 → rd_data_a = 0, rd_ready_a = 1.
- Write/read: write x7 = 0xDEADBEEF; next cycle read x7 on A and B → both 0xDEADBEEF one cycle later. Write x0 = 0x1234 and read it → 0.
- Scoreboard: rsv x3 → read x3 gives ready 0. Write x3 = 0x55 → read x3 gives ready 1, data 0x55. Same-cycle rsv x3 plus write x3 → ready stays 0.
- Collision: write x9 = 0xAAAA while reading x9 (old value 0x1111):
  - without REGFILE_BYPASS_EN → 0x1111;
  - with it → 0xAAAA.
- Reset mid-operation: write x4 = 0x77, reserve x6, assert rst for 1 cycle then release:
  - busy high for 32 cycles;
  - requests during busy are ignored;
  - afterwards x4 reads 0 and x6 reads ready 1.
- Hold: with rd_en_a low for 3 cycles while x2 is written → rd_data_a is unchanged.
